// File: rtl/pu_deny_if.sv
// ---------------------------------------------------------------------------
// pu_deny_if
//   Bundle of the request, write-drain, write-response and read-response
//   channels between a protection unit front end and pu_deny_responder.
//
//   Handshake rule for every channel: a transfer happens on the rising ACLK
//   edge where VALID and READY are both high. Once raised, VALID stays high
//   and the payload stays constant until that edge. READY may change freely.
//
//   Modports:
//     master - the initiator side (front end / AXI master view)
//     slave  - the responder side (pu_deny_responder)
// ---------------------------------------------------------------------------
interface pu_deny_if #(
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
) ();

  // Denied request channel
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic [ID_WIDTH-1:0]   REQ_ID;
  logic [7:0]            REQ_LEN;
  logic                  REQ_READ_WRITE;

  // Write data channel (drained)
  logic                  WVALID;
  logic                  WREADY;
  logic                  WLAST;

  // Write response channel
  logic                  BVALID;
  logic                  BREADY;
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;

  // Read data channel
  logic                  RVALID;
  logic                  RREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;

  modport master (
    output REQ_VALID, REQ_ID, REQ_LEN, REQ_READ_WRITE,
    input  REQ_READY,
    output WVALID, WLAST,
    input  WREADY,
    input  BVALID, BID, BRESP,
    output BREADY,
    input  RVALID, RID, RDATA, RRESP, RLAST,
    output RREADY
  );

  modport slave (
    input  REQ_VALID, REQ_ID, REQ_LEN, REQ_READ_WRITE,
    output REQ_READY,
    input  WVALID, WLAST,
    output WREADY,
    output BVALID, BID, BRESP,
    input  BREADY,
    output RVALID, RID, RDATA, RRESP, RLAST,
    input  RREADY
  );

endinterface

// File: rtl/pu_deny_responder.sv
// ---------------------------------------------------------------------------
// pu_deny_responder
//   Completes AXI transactions refused by the protection policy so the
//   initiating master never hangs. A denied write has all its W beats
//   drained (up to WLAST) and gets one DECERR B response. A denied read gets
//   LEN+1 R beats carrying DECERR and zero data. One request at a time.
//
//   Ports:
//     ACLK        clock, rising edge
//     ARESETN     asynchronous active-low reset
//     bus         pu_deny_if.slave: REQ / W / B / R channels
//     BUSY        high whenever a request is being serviced
//     dbg_state   current FSM state (state_t encoding), for checkers
//     DENY_COUNT  saturating count of accepted requests
//                 (present only when PU_DENY_COUNTER_EN is defined)
//
//   Every handshake output is a decode of registered state, so there is no
//   combinational path from any input to any output.
// ---------------------------------------------------------------------------
module pu_deny_responder #(
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  pu_deny_if.slave   bus,
  output logic       BUSY,
  output logic [1:0] dbg_state
`ifdef PU_DENY_COUNTER_EN
  ,
  output logic [31:0] DENY_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    W_DRAIN = 2'd1,
    B_RESP  = 2'd2,
    R_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;

  logic req_hs;
  logic last_beat;

  // Requests are only taken in IDLE, so REQ_READY is simply the IDLE decode.
  assign req_hs    = (state_q == IDLE) && bus.REQ_VALID;
  // The counter never passes len_q, so an 8-bit counter is enough even for
  // LEN = 255.
  assign last_beat = (cnt_q == len_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          id_d    = bus.REQ_ID;
          len_d   = bus.REQ_LEN;
          cnt_d   = 8'd0;
          state_d = bus.REQ_READ_WRITE ? W_DRAIN : R_RESP;
        end
      end
      W_DRAIN: begin
        // The master's WLAST ends the drain; the captured LEN plays no part.
        if (bus.WVALID && bus.WLAST) begin
          state_d = B_RESP;
        end
      end
      B_RESP: begin
        if (bus.BREADY) begin
          state_d = IDLE;
        end
      end
      R_RESP: begin
        if (bus.RREADY) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of registered state
  // -------------------------------------------------------------------------
  assign bus.REQ_READY = (state_q == IDLE);
  assign bus.WREADY    = (state_q == W_DRAIN);
  assign bus.BVALID    = (state_q == B_RESP);
  assign bus.BID       = id_q;
  assign bus.BRESP     = 2'b11;
  assign bus.RVALID    = (state_q == R_RESP);
  assign bus.RID       = id_q;
  assign bus.RDATA     = {DATA_WIDTH{1'b0}};
  assign bus.RRESP     = 2'b11;
  assign bus.RLAST     = (state_q == R_RESP) && last_beat;
  assign BUSY          = (state_q != IDLE);
  assign dbg_state     = state_q;

`ifdef PU_DENY_COUNTER_EN
  // -------------------------------------------------------------------------
  // Saturating count of accepted denied requests; only reset clears it.
  // -------------------------------------------------------------------------
  logic [31:0] deny_count_q, deny_count_d;

  always_comb begin
    deny_count_d = deny_count_q;
    if (req_hs && (deny_count_q != 32'hFFFF_FFFF)) begin
      deny_count_d = deny_count_q + 32'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      deny_count_q <= '0;
    end else begin
      deny_count_q <= deny_count_d;
    end
  end

  assign DENY_COUNT = deny_count_q;
`else
  // Request handshake only feeds the optional counter.
  logic unused_req_hs;
  assign unused_req_hs = req_hs;
`endif

endmodule

// File: tb/tb_pu_deny_responder.sv
// ---------------------------------------------------------------------------
// tb_pu_deny_responder
//   Directed and randomized checks of pu_deny_responder. Inputs are driven
//   and outputs sampled on the falling edge of ACLK. Expected read beats are
//   queued per request (one entry per beat: {RID, RLAST}) and retired on each
//   R handshake; writes are checked against the number of beats sent.
//   Build with +define+PU_DENY_COUNTER_EN to include DENY_COUNT checks.
// ---------------------------------------------------------------------------
module tb_pu_deny_responder;

  localparam int ID_W   = 16;
  localparam int DATA_W = 32;

  logic       ACLK;
  logic       ARESETN;
  logic       BUSY;
  logic [1:0] dbg_state;
`ifdef PU_DENY_COUNTER_EN
  logic [31:0] DENY_COUNT;
`endif

  pu_deny_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W)) bus ();

  pu_deny_responder #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .bus       (bus),
    .BUSY      (BUSY),
    .dbg_state (dbg_state)
`ifdef PU_DENY_COUNTER_EN
    ,
    .DENY_COUNT(DENY_COUNT)
`endif
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_req   = 0;                  // accepted requests since last reset
  logic [ID_W:0] exp_q[$];          // expected read beats {RID, RLAST}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.REQ_VALID      = 1'b0;
    bus.REQ_ID         = '0;
    bus.REQ_LEN        = '0;
    bus.REQ_READ_WRITE = 1'b0;
    bus.WVALID         = 1'b0;
    bus.WLAST          = 1'b0;
    bus.BREADY         = 1'b0;
    bus.RREADY         = 1'b0;
  endtask

  // ---------------- driver: denied read ----------------
  // mode 0: RREADY always high, 1: toggle 1,0,1,0..., 2: random
  task automatic do_read(input logic [ID_W-1:0] id, input logic [7:0] len, input int mode);
    int   guard;
    bit   phase;
    logic rr;
    @(negedge ACLK);
    check("r_req_ready_before", bus.REQ_READY, 1);
    bus.REQ_VALID      = 1'b1;
    bus.REQ_ID         = id;
    bus.REQ_LEN        = len;
    bus.REQ_READ_WRITE = 1'b0;
    bus.RREADY         = 1'b0;
    for (int b = 0; b <= int'(len); b++) exp_q.push_back({id, (b == int'(len))});
    n_req++;
    @(negedge ACLK);
    bus.REQ_VALID = 1'b0;
    guard = 0;
    phase = 1'b0;
    while (exp_q.size() > 0 && guard < 4 * (int'(len) + 1) + 8) begin
      check("r_rvalid",    bus.RVALID, 1);
      check("r_rid",       bus.RID, exp_q[0][ID_W:1]);
      check("r_rlast",     bus.RLAST, exp_q[0][0]);
      check("r_rdata",     bus.RDATA, 0);
      check("r_rresp",     bus.RRESP, 2'b11);
      check("r_req_ready", bus.REQ_READY, 0);
      check("r_wready",    bus.WREADY, 0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = ~phase;
        default: rr = 1'($urandom_range(0, 1));
      endcase
      phase = ~phase;
      bus.RREADY = rr;
      @(negedge ACLK);
      if (rr) void'(exp_q.pop_front());
      guard++;
    end
    check("r_all_beats", exp_q.size(), 0);
    exp_q.delete();
    bus.RREADY = 1'b0;
    check("r_rvalid_after", bus.RVALID, 0);
    check("r_ready_after",  bus.REQ_READY, 1);
    check("r_busy_after",   BUSY, 0);
  endtask

  // ---------------- driver: denied write ----------------
  task automatic do_write(input logic [ID_W-1:0] id, input int nbeats, input bit rand_w,
                          input int b_stall);
    int sent;
    int guard;
    @(negedge ACLK);
    check("w_req_ready_before", bus.REQ_READY, 1);
    bus.REQ_VALID      = 1'b1;
    bus.REQ_ID         = id;
    bus.REQ_LEN        = 8'($urandom_range(0, 255));  // irrelevant for writes
    bus.REQ_READ_WRITE = 1'b1;
    bus.WVALID         = 1'b1;                        // early beat must not be taken
    bus.WLAST          = 1'b0;
    bus.BREADY         = 1'b0;
    n_req++;
    check("w_no_early_wready", bus.WREADY, 0);
    @(negedge ACLK);
    bus.REQ_VALID = 1'b0;
    sent  = 0;
    guard = 0;
    while (sent < nbeats && guard < 8 * nbeats + 8) begin
      check("w_wready",    bus.WREADY, 1);
      check("w_no_bvalid", bus.BVALID, 0);
      check("w_busy",      BUSY, 1);
      bus.WVALID = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.WLAST  = (sent == nbeats - 1);
      @(negedge ACLK);
      if (bus.WVALID) sent++;
      guard++;
    end
    check("w_drained", sent, nbeats);
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    for (int i = 0; i < b_stall; i++) begin
      check("b_bvalid_stall", bus.BVALID, 1);
      check("b_bid_stall",    bus.BID, id);
      check("b_wready_off",   bus.WREADY, 0);
      @(negedge ACLK);
    end
    check("b_bvalid", bus.BVALID, 1);
    check("b_bid",    bus.BID, id);
    check("b_bresp",  bus.BRESP, 2'b11);
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    check("b_bvalid_after", bus.BVALID, 0);
    check("b_ready_after",  bus.REQ_READY, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset values
    check("rst_req_ready", bus.REQ_READY, 1);
    check("rst_wready",    bus.WREADY, 0);
    check("rst_bvalid",    bus.BVALID, 0);
    check("rst_rvalid",    bus.RVALID, 0);
    check("rst_rlast",     bus.RLAST, 0);
    check("rst_busy",      BUSY, 0);
    check("rst_bid",       bus.BID, 0);
    check("rst_rid",       bus.RID, 0);
`ifdef PU_DENY_COUNTER_EN
    check("rst_deny_count", DENY_COUNT, 0);
`endif
    ARESETN = 1'b1;

    // Single-beat read
    do_read(16'h0801, 8'd0, 0);
    // LEN=3 read with RREADY toggling
    do_read(16'h1234, 8'd3, 1);
    // 4-beat write, BREADY low for 3 cycles
    do_write(16'h0800, 4, 1'b0, 3);

    // Back-to-back: read LEN=0 then write held continuously on REQ
    @(negedge ACLK);
    bus.REQ_VALID = 1'b1; bus.REQ_ID = 16'h00AA; bus.REQ_LEN = 8'd0;
    bus.REQ_READ_WRITE = 1'b0; bus.RREADY = 1'b1;
    n_req++;
    @(negedge ACLK);
    check("b2b_rvalid", bus.RVALID, 1);
    check("b2b_rlast",  bus.RLAST, 1);
    check("b2b_rid",    bus.RID, 16'h00AA);
    bus.REQ_ID = 16'h00BB; bus.REQ_READ_WRITE = 1'b1;
    check("b2b_not_ready", bus.REQ_READY, 0);
    @(negedge ACLK);
    check("b2b_ready_again", bus.REQ_READY, 1);
    check("b2b_rvalid_off",  bus.RVALID, 0);
    n_req++;
    @(negedge ACLK);
    bus.REQ_VALID = 1'b0; bus.RREADY = 1'b0;
    check("b2b_wready",   bus.WREADY, 1);
    check("b2b_no_r",     bus.RVALID, 0);
    bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    @(negedge ACLK);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check("b2b_bvalid", bus.BVALID, 1);
    check("b2b_bid",    bus.BID, 16'h00BB);
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    check("b2b_idle", bus.REQ_READY, 1);

    // Randomized mix
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(16'($urandom), int'($urandom_range(1, 6)), 1'b1, int'($urandom_range(0, 3)));
      else
        do_read(16'($urandom), 8'($urandom_range(0, 12)), 2);
    end

    // Longest burst: 256 beats, no wrap
    do_read(16'hFFFF, 8'd255, 0);

`ifdef PU_DENY_COUNTER_EN
    check("cnt_running", DENY_COUNT, n_req);
`endif

    // Reset during beat 2 of a LEN=7 read
    @(negedge ACLK);
    bus.REQ_VALID = 1'b1; bus.REQ_ID = 16'h0707; bus.REQ_LEN = 8'd7;
    bus.REQ_READ_WRITE = 1'b0; bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.REQ_VALID = 1'b0;
    check("mid_beat1", bus.RVALID, 1);
    @(negedge ACLK);
    check("mid_beat2", bus.RVALID, 1);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.RVALID, 0);
    check("mid_rst_ready",  bus.REQ_READY, 1);
    check("mid_rst_busy",   BUSY, 0);
    check("mid_rst_rid",    bus.RID, 0);
    n_req = 0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("post_rst_rvalid", bus.RVALID, 0);
      check("post_rst_ready",  bus.REQ_READY, 1);
    end
    bus.RREADY = 1'b0;
    // Responder must still work after the abandoned burst
    do_read(16'h0808, 8'd1, 0);

`ifdef PU_DENY_COUNTER_EN
    for (int i = 0; i < 4; i++) do_read(16'(i), 8'd0, 0);
    check("cnt_five", DENY_COUNT, 32'd5);
    @(negedge ACLK);
    force dut.deny_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.deny_count_q;
    do_read(16'h0009, 8'd0, 0);
    check("cnt_saturate", DENY_COUNT, 32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_deny_responder.md
# pu_deny_responder

Protection-unit responder that completes AXI transactions the policy check has refused. The front end routes a denied request (ID, LEN, direction) here instead of forwarding it downstream. This block then finishes the protocol toward the initiating master so the bus never hangs: write data beats are drained and a DECERR write response is returned, or LEN+1 read beats are returned with DECERR and zero data.

## Interface
Parameters:
- ID_WIDTH, 16, width of transaction ID
- DATA_WIDTH, 32, width of RDATA

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  denied request present
- REQ_READY  out  1  responder accepts request
- REQ_ID  in  ID_WIDTH  ID of denied transaction
- REQ_LEN  in  8  AXI burst length (beats-1)
- REQ_READ_WRITE  in  1  0 = read, 1 = write
- WVALID  in  1  write beat from master
- WREADY  out  1  write beat accepted (discarded)
- WLAST  in  1  final write beat
- BVALID  out  1  write response valid
- BREADY  in  1  master accepts write response
- BID  out  ID_WIDTH  captured REQ_ID
- BRESP  out  2  always 2'b11 (DECERR)
- RVALID  out  1  read beat valid
- RREADY  in  1  master accepts read beat
- RID  out  ID_WIDTH  captured REQ_ID
- RDATA  out  DATA_WIDTH  always zero
- RRESP  out  2  always 2'b11 (DECERR)
- RLAST  out  1  final read beat
- BUSY  out  1  state != IDLE
- DENY_COUNT  out  32  denied-request count (only with PU_DENY_COUNTER_EN)

## Operation
- FSM states: IDLE, W_DRAIN, B_RESP, R_RESP.
- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID && REQ_READY: capture REQ_ID and REQ_LEN, clear the 8-bit beat counter.
  - Next state is W_DRAIN if REQ_READ_WRITE = 1, else R_RESP.
- W_DRAIN:
  - WREADY = 1; every beat is discarded.
  - On WVALID && WLAST, go to B_RESP.
  - REQ_LEN is not used for termination; WLAST alone ends the drain.
- B_RESP:
  - BVALID = 1 and is held stable with BID until BREADY.
  - On BVALID && BREADY, go to IDLE.
- R_RESP:
  - RVALID = 1; RLAST = (beat counter == captured LEN).
  - On RVALID && RREADY: if RLAST, go to IDLE; else increment the counter.
  - RID/RDATA/RRESP/RLAST stay stable while RVALID && !RREADY.
- Only one request is outstanding at a time. REQ_READY = 0 outside IDLE.
- BRESP and RRESP are constant 2'b11; RDATA is constant 0.

## Timing
- Reset values:
  - State IDLE.
  - REQ_READY = 1; WREADY, BVALID, RVALID, RLAST, BUSY = 0.
  - BID, RID, captured LEN, beat counter = 0.
  - DENY_COUNT = 0.
- All handshake outputs are registered state decodes; no combinational path from any input to any output.
- Latency from request accept:
  - Read: first RVALID one cycle after accept.
  - Write: WREADY one cycle after accept; BVALID one cycle after the WLAST handshake.
- Turnaround: REQ_READY returns one cycle after the final B or R handshake. Minimum request spacing is 2 cycles (read, LEN=0).
- LEN = 255: the 8-bit counter reaches 255, then RLAST; no wrap is possible.
- A W beat presented before the request is accepted is not taken (WREADY = 0).
- ARESETN asserted mid-burst: immediate return to IDLE with reset values. The partial burst is abandoned; no further beats are issued.

## Configuration
- PU_DENY_COUNTER_EN defined:
  - DENY_COUNT port exists: a 32-bit counter that increments on each REQ handshake.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by ARESETN.
- Undefined: DENY_COUNT port and counter are absent; all other behaviour is identical.

## Test plan
- Read, REQ_ID=16'h0801, LEN=0, RREADY=1 -> one beat next cycle with RID=16'h0801, RRESP=2'b11, RDATA=0, RLAST=1; REQ_READY=1 the following cycle.
- Read LEN=3 with RREADY toggling 1,0,1,0,... -> exactly 4 beats, outputs stable during stalls, RLAST only on the 4th.
- Write ID=16'h0800, 4 W beats with WLAST on the 4th, BREADY held low 3 cycles -> all beats accepted, BVALID held 3 cycles with BID=16'h0800, BRESP=2'b11, then IDLE.
- Back-to-back: read LEN=0 then write (1 beat) presented continuously -> second REQ accepted 2 cycles after the first; no beat overlap.
- ARESETN pulsed low during beat 2 of a LEN=7 read -> RVALID=0 and REQ_READY=1 while in reset; no further R beats.
- With PU_DENY_COUNTER_EN: 5 requests -> DENY_COUNT=5. Force counter to 32'hFFFFFFFF, 1 more request -> stays 32'hFFFFFFFF.
